// File: rtl/fetch_unit_pkg.sv
// Shared constants for the instruction-fetch stage: reset vector, NOP encoding,
// buffer depth and default address/data widths.
package fetch_unit_pkg;

    localparam int          FETCH_AW        = 32;
    localparam int          FETCH_DW        = 32;
    localparam logic [31:0] FETCH_RESET_PC  = 32'hBFC0_0000;
    localparam logic [31:0] FETCH_NOP       = 32'h0000_0000;
    localparam int          FETCH_BUF_DEPTH = 2;

endpackage

// File: rtl/fetch_unit_buf.sv
// Two-entry in-order buffer of fetched words {pc, inst, fault}. A clear discards
// all entries but may accept a simultaneous push, which becomes the only entry.
module fetch_unit_buf
    import fetch_unit_pkg::*;
#(
    parameter int AW = FETCH_AW,
    parameter int DW = FETCH_DW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [AW-1:0] push_pc,
    input  logic [DW-1:0] push_inst,
    input  logic          push_fault,
    input  logic          pop,
    input  logic          clr,
    output logic [AW-1:0] head_pc,
    output logic [DW-1:0] head_inst,
    output logic          head_fault,
    output logic [1:0]    count
);

    logic [AW-1:0] pc_mem    [FETCH_BUF_DEPTH];
    logic [DW-1:0] inst_mem  [FETCH_BUF_DEPTH];
    logic          fault_mem [FETCH_BUF_DEPTH];
    logic          rd_ptr;
    logic          wr_ptr;
    logic          do_pop;

    assign do_pop     = pop && (count != 2'd0);
    assign head_pc    = pc_mem[rd_ptr];
    assign head_inst  = inst_mem[rd_ptr];
    assign head_fault = fault_mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
            for (int i = 0; i < FETCH_BUF_DEPTH; i++) begin
                pc_mem[i]    <= '0;
                inst_mem[i]  <= FETCH_NOP;
                fault_mem[i] <= 1'b0;
            end
        end else if (clr) begin
            rd_ptr <= 1'b0;
            if (push) begin
                pc_mem[0]    <= push_pc;
                inst_mem[0]  <= push_inst;
                fault_mem[0] <= push_fault;
                wr_ptr       <= 1'b1;
                count        <= 2'd1;
            end else begin
                wr_ptr <= 1'b0;
                count  <= 2'd0;
            end
        end else begin
            if (push) begin
                pc_mem[wr_ptr]    <= push_pc;
                inst_mem[wr_ptr]  <= push_inst;
                fault_mem[wr_ptr] <= push_fault;
                wr_ptr            <= ~wr_ptr;
            end
            if (do_pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, do_pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    // The fetch credit rule must never let a push land on a full buffer.
    always @(posedge clk) begin
        if (!rst && !clr) begin
            assert (!(push && !do_pop && (count == 2'(FETCH_BUF_DEPTH))));
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues word reads and queues returned words
// for IF/ID. Optional macro FETCH_ALIGN_CHK_EN turns misaligned redirects into faults.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int            AW       = FETCH_AW,
    parameter int            DW       = FETCH_DW,
    parameter logic [AW-1:0] RESET_PC = AW'(FETCH_RESET_PC)
) (
    input  logic          clk,
    input  logic          rst,
    output logic          imem_req,
    output logic [AW-1:0] imem_addr,
    input  logic          imem_gnt,
    input  logic          imem_rvalid,
    input  logic [DW-1:0] imem_rdata,
    input  logic          stall,
    input  logic          redirect,
    input  logic [AW-1:0] redirect_pc,
    output logic          if_valid,
    output logic [AW-1:0] if_pc,
    output logic [DW-1:0] if_inst,
    output logic          if_fault
);

    // Handshakes: a read transfers on a cycle with imem_req && imem_gnt and its data
    // returns with imem_rvalid exactly one cycle later; IF/ID consumes the head on a
    // cycle with if_valid && !stall. A redirect overrides both in its cycle.

    logic [AW-1:0] pc_q;
    logic [AW-1:0] req_pc_q;
    logic          outstanding_q;
    logic          kill_q;
    logic          grant;
    logic          resp_ok;
    logic          redirect_fault;
    logic          fetch_halted;
    logic [AW-1:0] aligned_redirect_pc;
    logic [1:0]    count;
    logic [1:0]    in_use;
    logic          buf_push;
    logic [AW-1:0] buf_push_pc;
    logic [DW-1:0] buf_push_inst;
    logic          buf_push_fault;

    assign aligned_redirect_pc = redirect_pc & ~AW'(3);
    assign in_use    = count + {1'b0, outstanding_q};
    assign imem_req  = !rst && !redirect && !fetch_halted &&
                       (in_use < 2'(FETCH_BUF_DEPTH));
    assign imem_addr = pc_q;
    assign grant     = imem_req && imem_gnt;
    // Responses with no read in flight (e.g. straight after reset) are ignored.
    assign resp_ok   = imem_rvalid && outstanding_q && !kill_q && !redirect;

`ifdef FETCH_ALIGN_CHK_EN
    logic halt_q;

    assign redirect_fault = redirect && (redirect_pc[1:0] != 2'b00);
    assign fetch_halted   = halt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            halt_q <= 1'b0;
        end else if (redirect) begin
            halt_q <= redirect_fault;
        end
    end
`else
    assign redirect_fault = 1'b0;
    assign fetch_halted   = 1'b0;
`endif

    always_comb begin
        buf_push       = resp_ok;
        buf_push_pc    = req_pc_q;
        buf_push_inst  = imem_rdata;
        buf_push_fault = 1'b0;
        if (redirect_fault) begin
            buf_push       = 1'b1;
            buf_push_pc    = redirect_pc;
            buf_push_inst  = DW'(FETCH_NOP);
            buf_push_fault = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q          <= RESET_PC;
            req_pc_q      <= '0;
            outstanding_q <= 1'b0;
            kill_q        <= 1'b0;
        end else begin
            if (redirect) begin
                pc_q   <= aligned_redirect_pc;
                // A response arriving this very cycle is discarded by the clear.
                kill_q <= outstanding_q && !imem_rvalid;
            end else begin
                if (imem_rvalid) begin
                    kill_q <= 1'b0;
                end
                if (grant) begin
                    pc_q     <= pc_q + AW'(4);
                    req_pc_q <= pc_q;
                end
            end
            if (grant) begin
                outstanding_q <= 1'b1;
            end else if (imem_rvalid) begin
                outstanding_q <= 1'b0;
            end
        end
    end

    assign if_valid = (count != 2'd0);

    fetch_unit_buf #(
        .AW(AW),
        .DW(DW)
    ) u_buf (
        .clk        (clk),
        .rst        (rst),
        .push       (buf_push),
        .push_pc    (buf_push_pc),
        .push_inst  (buf_push_inst),
        .push_fault (buf_push_fault),
        .pop        (if_valid && !stall),
        .clr        (redirect),
        .head_pc    (if_pc),
        .head_inst  (if_inst),
        .head_fault (if_fault),
        .count      (count)
    );

endmodule
